// File: rtl/vga_fb_pkg.sv
// Purpose : shared constants for the VGA frame-buffer draw engine (op codes, geometry, FSM states).
// Latency : n/a (declarations only).
// Backpressure : n/a.
package vga_fb_pkg;

  // Default geometry: 640x480 display replicated 4x4 from a 160x120 buffer.
  localparam int DEF_FB_W       = 160;
  localparam int DEF_FB_H       = 120;
  localparam int DEF_SCALE_LOG2 = 2;
  localparam int DEF_XW         = 8;
  localparam int DEF_YW         = 7;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_PIXEL = 2'b01;
  localparam logic [1:0] OP_RECT  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_WAIT_VS = 2'd1;
  localparam state_t ST_FILL    = 2'd2;

endpackage

// File: rtl/vga_fb_draw_ram.sv
// Purpose : frame-buffer storage, one synchronous write port and one asynchronous read port.
// Latency : write lands at the clock edge; read is combinational (a same-cycle write is not visible).
// Backpressure : none, both ports accept every cycle.
// Ports: vga_clk clock; we/waddr/wdata write port; raddr/rdata read port.
module fb_ram_1w1r #(
  parameter int DEPTH = 19200,
  parameter int AW    = 15,
  parameter int DW    = 12
) (
  input  logic          vga_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge vga_clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vga_fb_draw.sv
// Purpose : pixel source for the VGA timing controller plus a fill engine (pixel/rect/clear).
// Latency : d_out zero-latency from row/col; a command of N pixels writes on the N edges after acceptance.
// Backpressure : cmd_ready only while idle; one command in flight, no queueing.
// Ports: vga_clk, rst (async high); row_addr/col_addr -> d_out read path; vs vsync;
//        cmd_valid/cmd_ready/cmd_op/cmd_sync/cmd_x0/x1/y0/y1/cmd_color command port; busy, done status.
module vga_fb_draw
  import vga_fb_pkg::*;
#(
  parameter int FB_W       = DEF_FB_W,
  parameter int FB_H       = DEF_FB_H,
  parameter int SCALE_LOG2 = DEF_SCALE_LOG2,
  parameter int XW         = DEF_XW,
  parameter int YW         = DEF_YW
) (
  input  logic          vga_clk,
  input  logic          rst,
  input  logic [8:0]    row_addr,
  input  logic [9:0]    col_addr,
  input  logic          vs,
  output logic [11:0]   d_out,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic          cmd_sync,
  input  logic [XW-1:0] cmd_x0,
  input  logic [XW-1:0] cmd_x1,
  input  logic [YW-1:0] cmd_y0,
  input  logic [YW-1:0] cmd_y1,
  input  logic [11:0]   cmd_color,
  output logic          busy,
  output logic          done
);

  localparam int DEPTH = FB_W * FB_H;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [XW-1:0] X_MAX  = XW'(FB_W - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(FB_H - 1);
  localparam logic [9:0]    DISP_W = 10'(FB_W << SCALE_LOG2);
  localparam logic [8:0]    DISP_H = 9'(FB_H << SCALE_LOG2);

  // Latched fill job; x_lo is kept so each row restarts at the left edge.
  typedef struct packed {
    logic [11:0]   color;
    logic [XW-1:0] x_lo;
    logic [XW-1:0] x_hi;
    logic [YW-1:0] y_hi;
  } fill_t;

  state_t        state;
  fill_t         fill;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          vs_q;
  logic          vs_rise;
  logic          accept;

  // Clipped bounds of the command on the port.
  logic [XW-1:0] c_x_lo, c_x_hi;
  logic [YW-1:0] c_y_lo, c_y_hi;
  logic          c_empty;

  always_comb begin
    c_x_lo  = cmd_x0;
    c_x_hi  = cmd_x0;
    c_y_lo  = cmd_y0;
    c_y_hi  = cmd_y0;
    c_empty = 1'b0;
    case (cmd_op)
      OP_NOP:   c_empty = 1'b1;
      OP_PIXEL: c_empty = (cmd_x0 > X_MAX) || (cmd_y0 > Y_MAX);
      OP_RECT: begin
        c_x_hi  = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
        c_y_hi  = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
        // With x0 on-screen, x0 > clamped x1 is the same as x0 > x1.
        c_empty = (cmd_x0 > X_MAX) || (cmd_y0 > Y_MAX) ||
                  (cmd_x0 > c_x_hi) || (cmd_y0 > c_y_hi);
      end
      default: begin
        c_x_lo = '0;
        c_x_hi = X_MAX;
        c_y_lo = '0;
        c_y_hi = Y_MAX;
      end
    endcase
  end

  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign busy      = (state == ST_WAIT_VS) || (state == ST_FILL);
  assign accept    = cmd_valid && cmd_ready;
  assign vs_rise   = vs && !vs_q;

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      fill  <= '0;
      x     <= '0;
      y     <= '0;
      vs_q  <= 1'b0;
      done  <= 1'b0;
    end else begin
      vs_q <= vs;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (c_empty) begin
              done <= 1'b1;
            end else begin
              fill  <= '{color: cmd_color, x_lo: c_x_lo, x_hi: c_x_hi, y_hi: c_y_hi};
              x     <= c_x_lo;
              y     <= c_y_lo;
              state <= cmd_sync ? ST_WAIT_VS : ST_FILL;
            end
          end
        end
        ST_WAIT_VS: begin
          if (vs_rise) begin
            state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (x == fill.x_hi) begin
            x <= fill.x_lo;
            if (y == fill.y_hi) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              y <= y + 1'b1;
            end
          end else begin
            x <= x + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read path: replicate each buffer pixel 2**SCALE_LOG2 times in both axes.
  logic [XW-1:0] fx;
  logic [YW-1:0] fy;
  logic          in_range;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic [11:0]   rd_dat;

  assign fx       = XW'(col_addr >> SCALE_LOG2);
  assign fy       = YW'(row_addr >> SCALE_LOG2);
  assign in_range = (col_addr < DISP_W) && (row_addr < DISP_H);
  // Off-screen reads are steered to address 0 so the RAM index stays in range.
  assign rd_addr  = in_range ? (AW'(fy) * AW'(FB_W) + AW'(fx)) : '0;
  assign wr_addr  = AW'(y) * AW'(FB_W) + AW'(x);
  assign d_out    = in_range ? rd_dat : 12'h000;

  fb_ram_1w1r #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (12)
  ) u_ram (
    .vga_clk (vga_clk),
    .we      (state == ST_FILL),
    .waddr   (wr_addr),
    .wdata   (fill.color),
    .raddr   (rd_addr),
    .rdata   (rd_dat)
  );

endmodule

// File: tb/tb_vga_fb_draw.sv
// Purpose : scoreboard bench for vga_fb_draw; stimulus pushes expected done edges and read data.
// Latency : done is expected at accept edge + pixel count; reads are sampled the same cycle.
// Backpressure : commands are held until cmd_ready is seen high.
module tb_vga_fb_draw;
  import vga_fb_pkg::*;

  logic        vga_clk = 1'b0;
  logic        rst;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        vs;
  logic [11:0] d_out;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_sync;
  logic [7:0]  cmd_x0, cmd_x1;
  logic [6:0]  cmd_y0, cmd_y1;
  logic [11:0] cmd_color;
  logic        busy;
  logic        done;

  vga_fb_draw dut (
    .vga_clk   (vga_clk),
    .rst       (rst),
    .row_addr  (row_addr),
    .col_addr  (col_addr),
    .vs        (vs),
    .d_out     (d_out),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_sync  (cmd_sync),
    .cmd_x0    (cmd_x0),
    .cmd_x1    (cmd_x1),
    .cmd_y0    (cmd_y0),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .busy      (busy),
    .done      (done)
  );

  always #20 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  int          n_vec = 0;
  int          n_bad = 0;
  int          busy_cnt = 0;
  int          done_q[$];
  logic [11:0] rd_q[$];
  string       rd_name_q[$];
  logic        rd_probe = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows a done pulse or a read is probed.
  always @(negedge vga_clk) begin
    if (busy) busy_cnt++;
    if (rd_probe) begin
      if (rd_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL rd_unexpected: d_out=0x%0h with no expectation", d_out);
      end else begin
        chk(rd_name_q.pop_front(), int'(d_out), int'(rd_q.pop_front()));
      end
    end
    if (!rst && done) begin
      if (done_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL done_unexpected: done=1 at cycle %0d, expected none", cyc);
      end else begin
        chk("done_edge", cyc, done_q.pop_front());
      end
    end
  end

  task automatic probe(input string nm, input int row, input int col, input logic [11:0] exp);
    @(posedge vga_clk); #1;
    row_addr = 9'(row);
    col_addr = 10'(col);
    rd_q.push_back(exp);
    rd_name_q.push_back(nm);
    rd_probe = 1'b1;
    @(posedge vga_clk); #1;
    rd_probe = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic sync, input int x0, input int y0,
                          input int x1, input int y1, input logic [11:0] col, input int n,
                          output int k);
    int t;
    @(negedge vga_clk);
    cmd_op = op; cmd_sync = sync; cmd_color = col;
    cmd_x0 = 8'(x0); cmd_y0 = 7'(y0); cmd_x1 = 8'(x1); cmd_y1 = 7'(y1);
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge vga_clk); t++; end
    chk("cmd_ready_seen", int'(cmd_ready), 1);
    k = cyc + 1;
    if (n >= 0) done_q.push_back(k + n);
    @(posedge vga_clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done_q.size() != 0 && t < 30000) begin @(negedge vga_clk); t++; end
    chk("done_pending", done_q.size(), 0);
    done_q.delete();
  endtask

  initial begin
    #2400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k, c, cnt;
    rst = 1'b1; vs = 1'b0; row_addr = '0; col_addr = '0;
    cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_sync = 1'b0;
    cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0; cmd_color = '0;

    // 1: reset state, full clear, in/out-of-range reads
    repeat (3) @(negedge vga_clk);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    #1 chk("post_rst_ready", int'(cmd_ready), 1);
    send_cmd(OP_CLEAR, 1'b0, 0, 0, 0, 0, 12'hF00, 19200, k);
    wait_done();
    probe("clr_0_0", 0, 0, 12'hF00);
    probe("clr_479_639", 479, 639, 12'hF00);
    probe("clr_240_320", 240, 320, 12'hF00);
    probe("clr_0_639", 0, 639, 12'hF00);
    probe("oor_col640", 0, 640, 12'h000);
    probe("oor_row480", 480, 0, 12'h000);
    probe("oor_col1023", 100, 1023, 12'h000);

    // 2: single pixel (5,3), busy for exactly one cycle
    busy_cnt = 0;
    send_cmd(OP_PIXEL, 1'b0, 5, 3, 0, 0, 12'h0F0, 1, k);
    wait_done();
    chk("pixel_busy_cycles", busy_cnt, 1);
    probe("px_12_20", 12, 20, 12'h0F0);
    probe("px_15_23", 15, 23, 12'h0F0);
    probe("px_12_24", 12, 24, 12'hF00);
    probe("px_11_20", 11, 20, 12'hF00);

    // 3: rect clipped at the right/bottom edges (y1 limited to 7 bits -> 127)
    send_cmd(OP_RECT, 1'b0, 150, 110, 200, 127, 12'h00F, 100, k);
    wait_done();
    probe("rect_br", 476, 636, 12'h00F);
    probe("rect_tl", 440, 600, 12'h00F);
    probe("rect_left", 440, 596, 12'hF00);
    probe("rect_above", 436, 600, 12'hF00);
    probe("rect_nowrap", 0, 0, 12'hF00);

    // 4: empty rect x0>x1: done next cycle, ready stays high, no writes
    send_cmd(OP_RECT, 1'b0, 10, 0, 5, 5, 12'hABC, 0, k);
    chk("empty_ready", int'(cmd_ready), 1);
    wait_done();
    probe("empty_x10", 0, 40, 12'hF00);
    probe("empty_x5", 0, 20, 12'hF00);

    // 5: vsync-aligned rect (0,0)-(1,0)
    send_cmd(OP_RECT, 1'b1, 0, 0, 1, 0, 12'h0FF, -1, k);
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge vga_clk);
      if (busy) cnt++;
    end
    chk("sync_busy_wait", cnt, 1000);
    probe("sync_nowrite", 0, 0, 12'hF00);
    @(negedge vga_clk);
    vs = 1'b1;
    c = cyc;
    done_q.push_back(c + 3);
    wait_done();
    probe("sync_x0", 0, 0, 12'h0FF);
    probe("sync_x1", 0, 4, 12'h0FF);
    probe("sync_x2", 0, 8, 12'hF00);
    vs = 1'b0;

    // 6: reset mid-clear, then a normal command
    send_cmd(OP_CLEAR, 1'b0, 0, 0, 0, 0, 12'h000, -1, k);
    repeat (50) @(negedge vga_clk);
    rst = 1'b1;
    #1;
    chk("midrst_ready", int'(cmd_ready), 0);
    chk("midrst_busy", int'(busy), 0);
    repeat (2) @(negedge vga_clk);
    rst = 1'b0;
    repeat (3) @(negedge vga_clk);
    probe("partial_written", 0, 40, 12'h000);
    probe("partial_untouched", 0, 400, 12'hF00);
    send_cmd(OP_PIXEL, 1'b0, 7, 7, 0, 0, 12'h888, 1, k);
    wait_done();
    probe("after_rst_px", 28, 28, 12'h888);

    repeat (2) @(negedge vga_clk);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
